// File: rtl/mem_port_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, transaction
// owner encoding and the byte-enable width helper.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    IFETCH = 2'd1,
    DMEM   = 2'd2
  } arb_owner_t;

  localparam int XLEN_DEFAULT = 32;
  localparam int BE_W         = XLEN_DEFAULT / 8;

  function automatic int be_width(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/mem_port_arb_pick.sv
// Grant selection between fetch and data requesters, with the streak counter
// that forces a fetch grant after STREAK_MAX data grants while fetch waits.
module mem_port_arb_pick
  import mem_port_arb_pkg::*;
#(
  parameter int STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic if_req,
  input  logic dm_req,
  output logic if_pick,
  output logic dm_pick
);

  logic [3:0] streak_r;

  // Data has priority unless fetch has already waited STREAK_MAX grants.
  always_comb begin
    if_pick = 1'b0;
    dm_pick = 1'b0;
    if (en && if_req && (!dm_req || (streak_r == 4'(STREAK_MAX)))) begin
      if_pick = 1'b1;
    end else if (en && dm_req) begin
      dm_pick = 1'b1;
    end else begin
      if_pick = 1'b0;
      dm_pick = 1'b0;
    end
  end

  // Streak counter: counts data grants that bypassed a waiting fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_r <= 4'd0;
    end else if (dm_pick && if_req) begin
      if (streak_r != 4'(STREAK_MAX)) begin
        streak_r <= streak_r + 4'd1;
      end
    end else if (if_pick || dm_pick) begin
      streak_r <= 4'd0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and data stages, one
// transaction in flight. Optional watchdog: MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int STREAK_MAX  = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [XLEN-1:0]     if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [XLEN/8-1:0]   dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [XLEN-1:0]     dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [XLEN-1:0]     dm_rdata,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                bus_we,
  output logic [XLEN/8-1:0]   bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic                bus_rvalid,
  input  logic [XLEN-1:0]     bus_rdata
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  ,
  output logic                bus_timeout
`endif
);

  localparam int BE_WIDTH = be_width(XLEN);

  arb_state_t      state_r, state_nxt_s;
  arb_owner_t      owner_r;
  logic            if_pick_s, dm_pick_s;
  logic            tmo_hit_s;
  logic            rsp_fire_s;
  logic [XLEN-1:0] rsp_data_s;

  mem_port_arb_pick #(
    .STREAK_MAX(STREAK_MAX)
  ) u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_r == IDLE),
    .if_req (if_req),
    .dm_req (dm_req),
    .if_pick(if_pick_s),
    .dm_pick(dm_pick_s)
  );

  assign if_gnt = if_pick_s;
  assign dm_gnt = dm_pick_s;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Watchdog counter restarts on every state entry; progress wins over expiry.
  always_ff @(posedge clk) begin
    if (!rst_n || (state_r == IDLE) || (state_nxt_s != state_r)) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  assign tmo_hit_s = (state_r != IDLE) && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) &&
                     !((state_r == REQ) && bus_ready) && !((state_r == RSP) && bus_rvalid);

  // One-cycle timeout indication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= tmo_hit_s;
    end
  end
`else
  localparam int timeout_cyc_unused = TIMEOUT_CYC;
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = (if_pick_s || dm_pick_s) ? REQ : IDLE;
      REQ:     state_nxt_s = bus_ready ? RSP : (tmo_hit_s ? IDLE : REQ);
      RSP:     state_nxt_s = (bus_rvalid || tmo_hit_s) ? IDLE : RSP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Response completion: real data in RSP, or zero data on watchdog expiry.
  always_comb begin
    rsp_fire_s = 1'b0;
    rsp_data_s = {XLEN{1'b0}};
    if ((state_r == RSP) && bus_rvalid) begin
      rsp_fire_s = 1'b1;
      rsp_data_s = bus_rdata;
    end else if (tmo_hit_s) begin
      rsp_fire_s = 1'b1;
      rsp_data_s = {XLEN{1'b0}};
    end else begin
      rsp_fire_s = 1'b0;
      rsp_data_s = {XLEN{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request capture, bus request hold, and owner-steered response delivery.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_r   <= NONE;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= {BE_WIDTH{1'b0}};
      bus_addr  <= {ADDR_W{1'b0}};
      bus_wdata <= {XLEN{1'b0}};
      if_rvalid <= 1'b0;
      if_rdata  <= {XLEN{1'b0}};
      dm_rvalid <= 1'b0;
      dm_rdata  <= {XLEN{1'b0}};
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if (if_pick_s) begin
        owner_r   <= IFETCH;
        bus_valid <= 1'b1;
        bus_we    <= 1'b0;
        bus_be    <= {BE_WIDTH{1'b1}};
        bus_addr  <= if_addr;
        bus_wdata <= {XLEN{1'b0}};
      end else if (dm_pick_s) begin
        owner_r   <= DMEM;
        bus_valid <= 1'b1;
        bus_we    <= dm_we;
        bus_be    <= dm_be;
        bus_addr  <= dm_addr;
        bus_wdata <= dm_wdata;
      end else if ((state_r == REQ) && (bus_ready || tmo_hit_s)) begin
        bus_valid <= 1'b0;
      end
      if (rsp_fire_s) begin
        owner_r <= NONE;
        case (owner_r)
          IFETCH: begin
            if_rvalid <= 1'b1;
            if_rdata  <= rsp_data_s;
          end
          DMEM: begin
            dm_rvalid <= 1'b1;
            dm_rdata  <= rsp_data_s;
          end
          default: begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; covers the watchdog
// scenario when MEM_PORT_ARBITER_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int TCYC = 8;
`else
  localparam int TCYC = 256;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = 4'h0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        bus_valid, bus_we;
  logic        bus_ready = 1'b0;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  logic        bus_timeout;
`endif

  int total = 0;
  int bad = 0;

  mem_port_arbiter #(
    .XLEN(32), .ADDR_W(32), .STREAK_MAX(4), .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_be(bus_be),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    , .bus_timeout(bus_timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the REQ cycle: accept now, respond next cycle; returns in the rvalid cycle.
  task automatic run_bus(input logic [31:0] rd);
    bus_ready = 1'b1;
    step();
    bus_ready  = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = rd;
    step();
    bus_rvalid = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst_n = 1'b1;
    check_val("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check_val("rst_rvalids", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    check_val("rst_bus_addr", bus_addr, 32'd0);

    // Fetch only
    if_req = 1'b1; if_addr = 32'h0000_0100;
    #1;
    check_val("f_gnt", {30'd0, if_gnt, dm_gnt}, 32'd2);
    step();
    if_req = 1'b0;
    check_val("f_bus_req", {27'd0, bus_valid, bus_we, bus_be}, {27'd0, 1'b1, 1'b0, 4'hF});
    check_val("f_bus_addr", bus_addr, 32'h0000_0100);
    run_bus(32'hDEAD_BEEF);
    check_val("f_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd2);
    check_val("f_rdata", if_rdata, 32'hDEAD_BEEF);
    check_val("f_idle_bus", {31'd0, bus_valid}, 32'd0);
    step();
    check_val("f_pulse_end", {30'd0, if_rvalid, dm_rvalid}, 32'd0);

    // Simultaneous requests, streak 0: data first, fetch next
    if_req = 1'b1; if_addr = 32'h0000_0104;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_0400;
    #1;
    check_val("both_gnt", {30'd0, if_gnt, dm_gnt}, 32'd1);
    step();
    dm_req = 1'b0;
    check_val("both_bus_addr", bus_addr, 32'h0000_0400);
    run_bus(32'h0000_7777);
    check_val("both_dm_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd1);
    check_val("both_dm_rdata", dm_rdata, 32'h0000_7777);
    #1;
    check_val("both_then_if", {30'd0, if_gnt, dm_gnt}, 32'd2);
    step();
    run_bus(32'h0000_0AAA);
    check_val("both_if_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd2);

    // Streak limiter: D,D,D,D,I,D,D,D,D,I
    dm_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_val($sformatf("streak_%0d", i), {30'd0, if_gnt, dm_gnt},
                (i == 4 || i == 9) ? 32'd2 : 32'd1);
      step();
      run_bus(32'h0000_0AAA);
    end
    if_req = 1'b0; dm_req = 1'b0;

    // Store held off by bus_ready for 5 cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011;
    dm_addr = 32'h0000_0200; dm_wdata = 32'hCAFE_F00D;
    #1;
    check_val("st_gnt", {30'd0, if_gnt, dm_gnt}, 32'd1);
    step();
    dm_req = 1'b0; dm_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("st_ctl_%0d", i), {26'd0, bus_valid, bus_we, bus_be},
                {26'd0, 1'b1, 1'b1, 4'b0011});
      check_val($sformatf("st_addr_%0d", i), bus_addr, 32'h0000_0200);
      check_val($sformatf("st_wdata_%0d", i), bus_wdata, 32'hCAFE_F00D);
      step();
    end
    run_bus(32'h0000_0055);
    check_val("st_ack", {30'd0, if_rvalid, dm_rvalid}, 32'd1);
    check_val("st_rdata", dm_rdata, 32'h0000_0055);
    check_val("st_if_hold", if_rdata, 32'h0000_0AAA);
    step();
    check_val("st_pulse_end", {31'd0, dm_rvalid}, 32'd0);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    // Watchdog: bus_ready never arrives
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300; dm_be = 4'hF;
    step();
    dm_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_val($sformatf("tmo_wait_%0d", i), {30'd0, bus_timeout, bus_valid}, 32'd1);
      step();
    end
    check_val("tmo_hit_last", {30'd0, bus_timeout, bus_valid}, 32'd1);
    step();
    check_val("tmo_pulse", {29'd0, bus_timeout, dm_rvalid, bus_valid}, 32'd6);
    check_val("tmo_rdata", dm_rdata, 32'd0);
    step();
    check_val("tmo_pulse_end", {30'd0, bus_timeout, dm_rvalid}, 32'd0);
`endif

    // Reset in RSP; a late bus_rvalid after release must be ignored
    if_req = 1'b1; if_addr = 32'h0000_0108;
    step();
    if_req = 1'b0; bus_ready = 1'b1;
    step();
    bus_ready = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0000_1234;
    step();
    bus_rvalid = 1'b0;
    check_val("rst_mid_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    check_val("rst_mid_bus", {26'd0, bus_valid, bus_we, bus_be}, 32'd0);
    check_val("rst_mid_rdata", if_rdata | dm_rdata | bus_addr | bus_wdata, 32'd0);
    step();
    check_val("rst_mid_quiet", {29'd0, if_rvalid, dm_rvalid, bus_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
